// File: rtl/gpio_pad_pkg.sv
// Shared register map for the GPIO pad control block.
package gpio_pad_pkg;
  localparam int ADDR_W = 3;
  localparam logic [ADDR_W-1:0] ADDR_OUT    = 3'd0;
  localparam logic [ADDR_W-1:0] ADDR_OE     = 3'd1;
  localparam logic [ADDR_W-1:0] ADDR_IE     = 3'd2;
  localparam logic [ADDR_W-1:0] ADDR_IN     = 3'd3;
  localparam logic [ADDR_W-1:0] ADDR_IRQ_EN = 3'd4;
  localparam logic [ADDR_W-1:0] ADDR_PEND   = 3'd5;
  localparam logic [ADDR_W-1:0] ADDR_RISE   = 3'd6;
endpackage

// File: rtl/gpio_pin_filter.sv
// One pad input: synchroniser, debounce counter and edge detect on the debounced value.
module gpio_pin_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CYCLES  = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic pin,
  output logic deb,
  output logic rise,
  output logic fall
);
  logic [SYNC_STAGES-1:0] sync;
  logic [7:0]             cnt;
  logic                   deb_q;
  logic                   s;

  assign s    = sync[SYNC_STAGES-1];
  assign rise = deb & ~deb_q;
  assign fall = ~deb & deb_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync  <= '0;
      cnt   <= '0;
      deb   <= 1'b0;
      deb_q <= 1'b0;
    end else begin
      sync  <= {sync[SYNC_STAGES-2:0], pin};
      deb_q <= deb;
      // counter only runs while the synced value disagrees with deb
      if (s == deb) begin
        cnt <= '0;
      end else if (cnt + 8'd1 == 8'(DEB_CYCLES)) begin
        deb <= s;
        cnt <= '0;
      end else begin
        cnt <= cnt + 8'd1;
      end
    end
  end
endmodule

// File: rtl/gpio_pad_ctrl.sv
// GPIO pad control: o/oe/ie registers, debounced inputs, edge-pending interrupt.
module gpio_pad_ctrl
  import gpio_pad_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CYCLES  = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [WIDTH-1:0]  pad_i,
  output logic [WIDTH-1:0]  pad_o,
  output logic [WIDTH-1:0]  pad_oe,
  output logic [WIDTH-1:0]  pad_ie,
  input  logic              reg_wen,
  input  logic              reg_ren,
  input  logic [ADDR_W-1:0] reg_addr,
  input  logic [WIDTH-1:0]  reg_wdata,
  output logic [WIDTH-1:0]  reg_rdata,
  output logic              reg_rvalid,
  output logic              irq
);
  logic [WIDTH-1:0] out_r, oe_r, ie_r, irq_en, pend, rise_sel;
  logic [WIDTH-1:0] deb, rise_v, fall_v, evt, clr, rd_mux;

  gpio_pin_filter #(.SYNC_STAGES(SYNC_STAGES), .DEB_CYCLES(DEB_CYCLES)) u_pin [WIDTH-1:0] (
    .clock (clock),
    .reset (reset),
    .pin   (pad_i),
    .deb   (deb),
    .rise  (rise_v),
    .fall  (fall_v)
  );

  assign pad_o  = out_r;
  assign pad_oe = oe_r;
  assign pad_ie = ie_r;
  assign evt    = (rise_sel & rise_v) | (~rise_sel & fall_v);
  assign clr    = (reg_wen && reg_addr == ADDR_PEND) ? reg_wdata : '0;

  always_comb begin
    rd_mux = '0;
    case (reg_addr)
      ADDR_OUT:    rd_mux = out_r;
      ADDR_OE:     rd_mux = oe_r;
      ADDR_IE:     rd_mux = ie_r;
      ADDR_IN:     rd_mux = deb;
      ADDR_IRQ_EN: rd_mux = irq_en;
      ADDR_PEND:   rd_mux = pend;
      ADDR_RISE:   rd_mux = rise_sel;
      default:     rd_mux = '0;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_r      <= '0;
      oe_r       <= '0;
      ie_r       <= '0;
      irq_en     <= '0;
      pend       <= '0;
      rise_sel   <= '0;
      irq        <= 1'b0;
      reg_rdata  <= '0;
      reg_rvalid <= 1'b0;
    end else begin
      if (reg_wen) begin
        case (reg_addr)
          ADDR_OUT:    out_r    <= reg_wdata;
          ADDR_OE:     oe_r     <= reg_wdata;
          ADDR_IE:     ie_r     <= reg_wdata;
          ADDR_IRQ_EN: irq_en   <= reg_wdata;
          ADDR_RISE:   rise_sel <= reg_wdata;
          default: ;
        endcase
      end
      // new events override a same-cycle W1C
      pend       <= (pend & ~clr) | evt;
      irq        <= |(pend & irq_en);
      reg_rvalid <= reg_ren;
      reg_rdata  <= reg_ren ? rd_mux : '0;
    end
  end
endmodule

// File: tb/tb_gpio_pad_ctrl.sv
// Directed + random checks of gpio_pad_ctrl against a window-based behavioural model.
module tb_gpio_pad_ctrl;
  import gpio_pad_pkg::*;
  localparam int W = 8, S = 2, DEB = 4;

  logic         clock = 1'b0, reset = 1'b1;
  logic [W-1:0] pad_ext = '0;
  logic [W-1:0] pad_i, pad_o, pad_oe, pad_ie, reg_wdata = '0, reg_rdata;
  logic         reg_wen = 1'b0, reg_ren = 1'b0, reg_rvalid, irq;
  logic [2:0]   reg_addr = '0;

  // wide and narrow instances with no filtering
  logic [31:0] s_ext = '0, s_wdata = '0, p32_i, p32_o, p32_oe, p32_ie, r32;
  logic        s_wen = 1'b0, s_ren = 1'b0, v32, q32;
  logic [2:0]  s_addr = '0;
  logic        p1_i, p1_o, p1_oe, p1_ie, r1, v1, q1;

  int vectors = 0, errors = 0;

  always #5 clock = ~clock;

  // the pad cell gates its input with ie
  assign pad_i = pad_ext & pad_ie;
  assign p32_i = s_ext & p32_ie;
  assign p1_i  = s_ext[0] & p1_ie;

  gpio_pad_ctrl #(.WIDTH(W), .SYNC_STAGES(S), .DEB_CYCLES(DEB)) dut (
    .clock(clock), .reset(reset), .pad_i(pad_i), .pad_o(pad_o), .pad_oe(pad_oe),
    .pad_ie(pad_ie), .reg_wen(reg_wen), .reg_ren(reg_ren), .reg_addr(reg_addr),
    .reg_wdata(reg_wdata), .reg_rdata(reg_rdata), .reg_rvalid(reg_rvalid), .irq(irq));

  gpio_pad_ctrl #(.WIDTH(32), .SYNC_STAGES(S), .DEB_CYCLES(1)) dut32 (
    .clock(clock), .reset(reset), .pad_i(p32_i), .pad_o(p32_o), .pad_oe(p32_oe),
    .pad_ie(p32_ie), .reg_wen(s_wen), .reg_ren(s_ren), .reg_addr(s_addr),
    .reg_wdata(s_wdata), .reg_rdata(r32), .reg_rvalid(v32), .irq(q32));

  gpio_pad_ctrl #(.WIDTH(1), .SYNC_STAGES(S), .DEB_CYCLES(1)) dut1 (
    .clock(clock), .reset(reset), .pad_i(p1_i), .pad_o(p1_o), .pad_oe(p1_oe),
    .pad_ie(p1_ie), .reg_wen(s_wen), .reg_ren(s_ren), .reg_addr(s_addr),
    .reg_wdata(s_wdata[0]), .reg_rdata(r1), .reg_rvalid(v1), .irq(q1));

  // reference model state
  logic [W-1:0] m_out, m_oe, m_ie, m_en, m_pend, m_rise, m_deb, m_debq, m_rdata;
  logic         m_irq, m_rvalid;
  logic [W-1:0] hist[$];  // hist[k] = gated pad input sampled k edges ago

  task automatic model_reset();
    m_out = '0; m_oe = '0; m_ie = '0; m_en = '0; m_pend = '0; m_rise = '0;
    m_deb = '0; m_debq = '0; m_rdata = '0; m_irq = 1'b0; m_rvalid = 1'b0;
    hist = {};
    for (int i = 0; i < S + DEB; i++) hist.push_back('0);
  endtask

  // deb takes a new value once DEB consecutive synced samples all disagree with it
  task automatic model_step();
    logic [W-1:0] nd, evt, clr, rd;
    bit all;
    if (reset) begin model_reset(); return; end
    hist.push_front(pad_ext & m_ie);
    nd = m_deb;
    for (int p = 0; p < W; p++) begin
      all = 1;
      for (int i = S; i < S + DEB; i++) if (hist[i][p] == m_deb[p]) all = 0;
      if (all) nd[p] = ~m_deb[p];
    end
    void'(hist.pop_back());
    evt = 0;
    for (int p = 0; p < W; p++)
      evt[p] = m_rise[p] ? (m_deb[p] && !m_debq[p]) : (!m_deb[p] && m_debq[p]);
    clr = (reg_wen && reg_addr == 3'd5) ? reg_wdata : '0;
    case (reg_addr)
      3'd0: rd = m_out;  3'd1: rd = m_oe;   3'd2: rd = m_ie;   3'd3: rd = m_deb;
      3'd4: rd = m_en;   3'd5: rd = m_pend; 3'd6: rd = m_rise; default: rd = '0;
    endcase
    m_rdata  = reg_ren ? rd : '0;
    m_rvalid = reg_ren;
    m_irq    = (m_pend & m_en) != 0;
    m_pend   = (m_pend & ~clr) | evt;
    if (reg_wen)
      case (reg_addr)
        3'd0: m_out = reg_wdata; 3'd1: m_oe = reg_wdata; 3'd2: m_ie = reg_wdata;
        3'd4: m_en = reg_wdata;  3'd6: m_rise = reg_wdata; default: ;
      endcase
    m_debq = m_deb;
    m_deb  = nd;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cmp_all();
    chk("pad_o", 32'(pad_o), 32'(m_out));
    chk("pad_oe", 32'(pad_oe), 32'(m_oe));
    chk("pad_ie", 32'(pad_ie), 32'(m_ie));
    chk("irq", 32'(irq), 32'(m_irq));
    chk("rvalid", 32'(reg_rvalid), 32'(m_rvalid));
    chk("rdata", 32'(reg_rdata), 32'(m_rdata));
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      model_step();
      #1;
      cmp_all();
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [W-1:0] d);
    reg_wen = 1'b1; reg_addr = a; reg_wdata = d;
    tick();
    reg_wen = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, input string tag, input logic [W-1:0] exp);
    reg_ren = 1'b1; reg_addr = a;
    tick();
    reg_ren = 1'b0;
    chk({tag, "_rvalid"}, 32'(reg_rvalid), 32'd1);
    chk(tag, 32'(reg_rdata), 32'(exp));
  endtask

  initial begin
    model_reset();
    tick(3);
    chk("rst_pad_oe", 32'(pad_oe), 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    reset = 1'b0;
    tick();

    // register write/read-back
    chk("rvalid_idle", 32'(reg_rvalid), 32'd0);
    wr(ADDR_OE, 8'hA5);
    chk("pad_oe_a5", 32'(pad_oe), 32'hA5);
    wr(ADDR_OUT, 8'h0F);
    chk("pad_o_0f", 32'(pad_o), 32'h0F);
    rd(ADDR_OE, "rd_oe", 8'hA5);
    rd(ADDR_OUT, "rd_out", 8'h0F);
    rd(3'd7, "rd_rsvd", 8'h00);
    wr(ADDR_IN, 8'hFF);
    rd(ADDR_IN, "rd_in_ro", 8'h00);

    // debounce latency and glitch rejection
    wr(ADDR_IE, 8'h01);
    pad_ext = 8'h01;
    tick(S + DEB - 1);
    rd(ADDR_IN, "in0_early", 8'h00);
    rd(ADDR_IN, "in0_settled", 8'h01);
    wr(ADDR_IE, 8'h03);
    pad_ext = 8'h03;
    tick(3);
    pad_ext = 8'h01;
    tick(10);
    rd(ADDR_IN, "in1_glitch", 8'h01);

    // rising-edge interrupt, W1C, falling edge ignored
    wr(ADDR_RISE, 8'h01);
    wr(ADDR_IRQ_EN, 8'h01);
    pad_ext = 8'h00;
    tick(10);
    rd(ADDR_PEND, "pend_fall_none", 8'h00);
    pad_ext = 8'h01;
    tick(S + DEB + 1);
    chk("irq_before", 32'(irq), 32'd0);
    tick();
    chk("irq_set", 32'(irq), 32'd1);
    rd(ADDR_PEND, "pend_rise", 8'h01);
    wr(ADDR_PEND, 8'h01);
    tick();
    chk("irq_cleared", 32'(irq), 32'd0);
    pad_ext = 8'h00;
    tick(10);
    rd(ADDR_PEND, "pend_fall", 8'h00);

    // same-cycle set and clear: set wins
    pad_ext = 8'h01;
    tick(10);
    pad_ext = 8'h00;
    tick(10);
    pad_ext = 8'h01;
    tick(S + DEB);
    wr(ADDR_PEND, 8'h01);
    rd(ADDR_PEND, "pend_set_wins", 8'h01);
    chk("irq_stays", 32'(irq), 32'd1);

    // randomized traffic against the model
    for (int c = 0; c < 600; c++) begin
      for (int p = 0; p < W; p++) if ($urandom_range(5) == 0) pad_ext[p] = ~pad_ext[p];
      reg_wen   = ($urandom_range(3) == 0);
      reg_ren   = $urandom_range(1);
      reg_addr  = 3'($urandom_range(7));
      reg_wdata = 8'($urandom);
      tick();
    end

    // reset mid-traffic
    reg_wen = 1'b1; reg_ren = 1'b1; reg_addr = ADDR_OE; reg_wdata = 8'hFF;
    tick();
    #2 reset = 1'b1;
    #1;
    model_reset();
    chk("rst_async_o", 32'(pad_o), 32'd0);
    chk("rst_async_oe", 32'(pad_oe), 32'd0);
    chk("rst_async_ie", 32'(pad_ie), 32'd0);
    chk("rst_async_irq", 32'(irq), 32'd0);
    chk("rst_async_rvalid", 32'(reg_rvalid), 32'd0);
    chk("rst_async_rdata", 32'(reg_rdata), 32'd0);
    reg_wen = 1'b0; reg_ren = 1'b0;
    tick(2);
    reset = 1'b0;
    rd(ADDR_IN, "in_after_rst", 8'h00);
    rd(ADDR_PEND, "pend_after_rst", 8'h00);

    // WIDTH=32 and WIDTH=1 with DEB_CYCLES=1
    s_wen = 1'b1; s_addr = ADDR_IE; s_wdata = 32'hFFFF_FFFF;
    tick();
    s_wen = 1'b0;
    s_ext = $urandom | 32'h1;
    tick(S);
    s_ren = 1'b1; s_addr = ADDR_IN;
    tick();
    chk("w32_in_early", r32, 32'd0);
    chk("w1_in_early", 32'(r1), 32'd0);
    tick();
    chk("w32_in", r32, s_ext);
    chk("w1_in", 32'(r1), 32'd1);
    chk("w32_rvalid", 32'(v32), 32'd1);
    s_ren = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
